// File: rtl/etcpu_pkg.sv
// rtl/etcpu_pkg.sv - shared constants and payload layout for the etcpu pipeline spine
package etcpu_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
        logic [XLEN_DEF-1:0] dat;
    } etcpu_pld_t;

    localparam int PLD_W_DEF = $bits(etcpu_pld_t);

endpackage

// File: rtl/etcpu_pipe_spine_if.sv
// rtl/etcpu_pipe_spine_if.sv - fetch handshake, per-stage payload buses, hazard controls and perf counters
interface etcpu_pipe_spine_if #(
    parameter int NUM_STG = 4,
    parameter int PLD_W   = 96
);
    logic                          in_vld;
    logic                          in_rdy;
    logic [NUM_STG-1:0][PLD_W-1:0] stg_pld_next;
    logic [NUM_STG-1:0][PLD_W-1:0] stg_pld;
    logic [NUM_STG-1:0]            stg_vld;
    logic                          intrlock_bubble;
    logic                          flush;
    logic                          mem_stall;
    logic [31:0]                   perf_cyc;
    logic [31:0]                   perf_ret;
    logic [31:0]                   perf_stl;

    modport master (
        output in_vld, stg_pld_next, intrlock_bubble, flush, mem_stall,
        input  in_rdy, stg_pld, stg_vld, perf_cyc, perf_ret, perf_stl
    );

    modport slave (
        input  in_vld, stg_pld_next, intrlock_bubble, flush, mem_stall,
        output in_rdy, stg_pld, stg_vld, perf_cyc, perf_ret, perf_stl
    );
endinterface

// File: rtl/etcpu_pipe_stg.sv
// rtl/etcpu_pipe_stg.sv - one pipeline boundary register: valid bit plus gated payload
module etcpu_pipe_stg #(
    parameter int PLD_W = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic             src_vld_i,
    input  logic [PLD_W-1:0] pld_next_i,
    output logic             vld_o,
    output logic [PLD_W-1:0] pld_o
);

    logic             vld_q, vld_d;
    logic [PLD_W-1:0] pld_q, pld_d;

    // Payload only loads behind a valid source so bubbles never toggle the wide register.
    always_comb begin
        vld_d = vld_q;
        pld_d = pld_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (adv_i) begin
            vld_d = src_vld_i;
            if (src_vld_i) begin
                pld_d = pld_next_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            pld_q <= '0;
        end else begin
            vld_q <= vld_d;
            pld_q <= pld_d;
        end
    end

    assign vld_o = vld_q;
    assign pld_o = pld_q;

endmodule

// File: rtl/etcpu_pipe_spine.sv
// rtl/etcpu_pipe_spine.sv - pipeline valid/payload spine with stall, interlock, flush; perf counters under ETCPU_PERF_CNT_EN
module etcpu_pipe_spine
    import etcpu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_STG   = 4,
    parameter int PLD_W     = PLD_W_DEF,
    parameter int FLUSH_STG = 2
) (
    input logic               clk,
    input logic               rst,
    etcpu_pipe_spine_if.slave bus
);

    generate
        if (NUM_STG < 2) begin : g_bad_num_stg
            $error("etcpu_pipe_spine: NUM_STG must be at least 2");
        end
        if (FLUSH_STG < 1 || FLUSH_STG > NUM_STG - 1) begin : g_bad_flush_stg
            $error("etcpu_pipe_spine: FLUSH_STG must lie in 1..NUM_STG-1");
        end
        if (PLD_W < XLEN) begin : g_bad_pld_w
            $error("etcpu_pipe_spine: PLD_W must be able to hold a PC");
        end
    endgenerate

    logic [NUM_STG-1:0]            vld;
    logic [NUM_STG-1:0][PLD_W-1:0] pld;

    assign bus.in_rdy  = !bus.mem_stall && !bus.intrlock_bubble && !rst;
    assign bus.stg_vld = vld;
    assign bus.stg_pld = pld;

    for (genvar g = 0; g < NUM_STG; g++) begin : g_stg
        localparam bit IS_FLUSHED = (g < FLUSH_STG);
        logic adv;
        logic src_vld;

        if (g == 0) begin : g_head
            assign adv     = !bus.mem_stall && !bus.intrlock_bubble;
            assign src_vld = bus.in_vld;
        end else begin : g_body
            // Stage 1 takes the interlock bubble; the first surviving stage must not inherit a wrong-path entry.
            localparam bit TAKES_BUBBLE = (g == 1);
            localparam bit FLUSH_EDGE   = (g == FLUSH_STG);
            assign adv     = !bus.mem_stall;
            assign src_vld = vld[g-1]
                           && !(TAKES_BUBBLE && bus.intrlock_bubble)
                           && !(FLUSH_EDGE && bus.flush);
        end

        etcpu_pipe_stg #(
            .PLD_W(PLD_W)
        ) u_stg (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (IS_FLUSHED && bus.flush),
            .adv_i     (adv),
            .src_vld_i (src_vld),
            .pld_next_i(bus.stg_pld_next[g]),
            .vld_o     (vld[g]),
            .pld_o     (pld[g])
        );
    end

`ifdef ETCPU_PERF_CNT_EN
    logic [31:0] perf_cyc_q, perf_cyc_d;
    logic [31:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_stl_q, perf_stl_d;

    // All three wrap naturally at 2^32.
    always_comb begin
        perf_cyc_d = perf_cyc_q + 32'd1;
        perf_ret_d = perf_ret_q + {31'd0, vld[NUM_STG-1] && !bus.mem_stall};
        perf_stl_d = perf_stl_q + {31'd0, bus.mem_stall || bus.intrlock_bubble};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cyc_q <= '0;
            perf_ret_q <= '0;
            perf_stl_q <= '0;
        end else begin
            perf_cyc_q <= perf_cyc_d;
            perf_ret_q <= perf_ret_d;
            perf_stl_q <= perf_stl_d;
        end
    end

    assign bus.perf_cyc = perf_cyc_q;
    assign bus.perf_ret = perf_ret_q;
    assign bus.perf_stl = perf_stl_q;
`else
    assign bus.perf_cyc = '0;
    assign bus.perf_ret = '0;
    assign bus.perf_stl = '0;
`endif

endmodule

// File: doc/etcpu_pipe_spine.md
ETCPU_PIPE_SPINE -- requirements
Module: etcpu_pipe_spine

Interface
REQ-001 Parameter XLEN, default 32: width of PC field carried with each stage.
REQ-002 Parameter NUM_STG, default 4: number of pipeline boundary registers (IF/ID ... MA/WB).
REQ-003 Parameter PLD_W, default 96: per-stage payload width (pc, inst, data packed by the instantiating core).
REQ-004 Parameter FLUSH_STG, default 2: number of youngest stages cleared on flush.
REQ-005 clk  in  1  clock, single domain; reset is asynchronous and active-high.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_vld  in  1  fetch stage presents a valid instruction.
REQ-008 in_rdy  out  1  spine accepts stage-0 entry this cycle; also the PC-advance enable.
REQ-009 stg_pld_next  in  NUM_STG x PLD_W  next payload per stage, from the combinational stage logic feeding it.
REQ-010 stg_pld  out  NUM_STG x PLD_W  registered payload per stage.
REQ-011 stg_vld  out  NUM_STG  valid bit per stage; index 0 youngest.
REQ-012 intrlock_bubble  in  1  load-use interlock: hold stage 0, insert bubble into stage 1.
REQ-013 flush  in  1  taken-branch/jump redirect; one-cycle pulse.
REQ-014 mem_stall  in  1  data memory not ready; freeze entire spine.
REQ-015 perf_cyc, perf_ret, perf_stl  out  32 each  performance counters (see Configuration).

Function
REQ-016 Per cycle, priority: rst > flush > mem_stall > intrlock_bubble > normal advance.
REQ-017 in_rdy SHALL equal !mem_stall & !intrlock_bubble & !rst, combinational.
REQ-018 Normal advance: stg_vld[0] <= in_vld; stg_vld[i] <= stg_vld[i-1] for i>=1; latency in_vld to stg_vld[NUM_STG-1] is exactly NUM_STG cycles.
REQ-019 Payload of stage i SHALL load stg_pld_next[i] only when the stage advances and its source is valid; otherwise it holds (gating).
REQ-020 mem_stall: all stg_vld and stg_pld hold; in_vld ignored.
REQ-021 intrlock_bubble without mem_stall: stage 0 holds, stg_vld[1] <= 0, stages 2..NUM_STG-1 advance.
REQ-022 flush: stg_vld[0..FLUSH_STG-1] <= 0 regardless of mem_stall or intrlock_bubble; older stages follow REQ-018/REQ-020/REQ-021 (stage FLUSH_STG receives 0 from flushed source).
REQ-023 flush held more than one cycle SHALL keep clearing each cycle; no internal state beyond vld/pld/counters.
REQ-024 NUM_STG < 2 or FLUSH_STG outside 1..NUM_STG-1 SHALL fail elaboration.

Reset
REQ-025 On rst assertion, asynchronously: stg_vld = 0, stg_pld = 0, perf counters = 0; in_rdy = 0 while rst high.
REQ-026 Reset mid-operation discards all in-flight instructions; first acceptance is the first clk edge after rst deasserts with in_vld high.

Configuration
REQ-027 Macro ETCPU_PERF_CNT_EN defined: perf_cyc increments every cycle; perf_ret increments when stg_vld[NUM_STG-1] is 1 and not frozen by mem_stall; perf_stl increments when in_rdy is 0 outside reset; all 32-bit, wrap 0xFFFFFFFF -> 0.
REQ-028 ETCPU_PERF_CNT_EN undefined: ports present, tied to 0, no counter flops.

Structure
REQ-029 Shared package etcpu_pkg holds XLEN default, NOP encoding 32'h00000013, and the payload struct typedef (pc, inst, dat).
REQ-030 One sub-module etcpu_pipe_stg (single vld+pld register with hold/clear) instantiated NUM_STG times; counters inline.

Verification
REQ-031 Reset, then in_vld=1 for 6 cycles with pld=PC 0,4,8.. -> stg_vld[3] rises at cycle 4, stg_pld[3] sequence 0,4,8.
REQ-032 intrlock_bubble one cycle with stg_vld=4'b1111 -> next cycle stg_vld=4'b1101, stage 0 payload unchanged, in_rdy=0 that cycle.
REQ-033 flush with mem_stall both high, stg_vld=4'b1111, FLUSH_STG=2 -> stg_vld=4'b1100, stages 2-3 payload held.
REQ-034 mem_stall 3 cycles -> all outputs frozen, perf_stl +3, perf_ret +0.
REQ-035 rst asserted mid-stream between edges -> stg_vld=0 immediately without clk edge; counters 0.
REQ-036 perf_cyc preloaded via force to 0xFFFFFFFE, 2 cycles -> reads 0x00000000; macro undefined build -> all perf ports 0.
